// File: rtl/rename_regfile_pkg.sv
// ---------------------------------------------------------------------------
// rename_regfile_pkg
//
// Purpose: shared constants and helpers for the rename register file slice.
//          Holds the architectural register count, the register index and
//          ROB tag widths, and the index of the hardwired-zero register x0.
//
// Contents:
//   REG_NUM        - number of architectural registers
//   REG_ID_BIT     - register index width
//   ROB_WIDTH_BIT  - ROB tag width
//   X0_IDX         - index of the hardwired-zero register
//   isArchWrite()  - true when an index names a writable register (not x0)
// ---------------------------------------------------------------------------
package rename_regfile_pkg;

    localparam int REG_NUM       = 32;
    localparam int REG_ID_BIT    = 5;
    localparam int ROB_WIDTH_BIT = 4;
    localparam int DATA_WIDTH    = 32;

    localparam logic [REG_ID_BIT-1:0] X0_IDX = '0;

    typedef logic [REG_ID_BIT-1:0]    regIdT;
    typedef logic [ROB_WIDTH_BIT-1:0] robTagT;
    typedef logic [DATA_WIDTH-1:0]    dataT;

    // x0 is hardwired to zero, so every write path must skip it.
    function automatic logic isArchWrite(input regIdT id);
        return (id != X0_IDX);
    endfunction

endpackage

// File: rtl/rename_regfile_read_port.sv
// ---------------------------------------------------------------------------
// rename_regfile_read_port
//
// Purpose: combinational operand lookup for one source register. Returns
//          either the stored value (not busy) or the ROB tag still pending
//          (busy). x0 always reads as not busy with value 0.
//
// Optional feature: when REGFILE_BYPASS_EN is defined, a commit whose ROB id
//          matches the pending tag of the looked-up register is forwarded to
//          the output in the same cycle, independent of rdy_in.
//
// Ports:
//   i_rs         - source register index
//   i_values     - stored register values (all registers)
//   i_busy       - stored busy bits (all registers)
//   i_tags       - stored rename tags (all registers)
//   i_writeEn    - commit strobe from the ROB
//   i_regId      - committed register index
//   i_robId      - committing ROB entry
//   i_valueIn    - committed value
//   o_busy       - operand still waits on a ROB entry
//   o_tag        - ROB entry to wait on (0 when not busy)
//   o_value      - operand value (0 when busy)
// ---------------------------------------------------------------------------
module rename_regfile_read_port
    import rename_regfile_pkg::*;
(
    input  logic [REG_ID_BIT-1:0]    i_rs,
    input  logic [DATA_WIDTH-1:0]    i_values [REG_NUM],
    input  logic                     i_busy   [REG_NUM],
    input  logic [ROB_WIDTH_BIT-1:0] i_tags   [REG_NUM],
    input  logic                     i_writeEn,
    input  logic [REG_ID_BIT-1:0]    i_regId,
    input  logic [ROB_WIDTH_BIT-1:0] i_robId,
    input  logic [DATA_WIDTH-1:0]    i_valueIn,
    output logic                     o_busy,
    output logic [ROB_WIDTH_BIT-1:0] o_tag,
    output logic [DATA_WIDTH-1:0]    o_value
);

`ifdef REGFILE_BYPASS_EN
    // The commit resolves this operand only if it is the exact producer the
    // register is waiting on; a stale commit from an older producer must not
    // be forwarded.
    logic w_bypassHit;
    assign w_bypassHit = i_writeEn && (i_regId == i_rs) && (i_tags[i_rs] == i_robId);
`else
    // Without forwarding the commit bus is not needed for lookup.
    logic w_unusedCommit;
    assign w_unusedCommit = ^{i_writeEn, i_regId, i_robId, i_valueIn};
`endif

    // Lookup: x0 reads as zero; a busy register exposes its tag and hides its
    // value; an idle register exposes its value and reports tag 0.
    always_comb begin
        o_busy  = 1'b0;
        o_tag   = '0;
        o_value = '0;
        if (i_rs != X0_IDX) begin
            if (i_busy[i_rs]) begin
`ifdef REGFILE_BYPASS_EN
                if (w_bypassHit) begin
                    o_value = i_valueIn;
                end else begin
                    o_busy = 1'b1;
                    o_tag  = i_tags[i_rs];
                end
`else
                o_busy = 1'b1;
                o_tag  = i_tags[i_rs];
`endif
            end else begin
                o_value = i_values[i_rs];
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// ---------------------------------------------------------------------------
// rename_regfile
//
// Purpose: architectural register file with per-register rename tags for the
//          out-of-order core. The decoder renames destinations to ROB entries
//          and reads operands; the ROB commit port retires results; a flush
//          clears every pending tag.
//
// Optional feature: REGFILE_BYPASS_EN enables commit-to-read forwarding in the
//          read ports (see rename_regfile_read_port).
//
// Ports:
//   clk_in, rst_in       - clock, asynchronous active-high reset
//   rdy_in               - low pauses all state updates
//   rename_en/_rd/_rob_id- destination rename from the decoder
//   rs1, rs2             - operand indices
//   rsN_busy/_tag/_value - operand lookup results (combinational)
//   write_en/reg_id/rob_id/value_in - ROB commit port
//   clear_all            - misprediction flush of all busy bits
// ---------------------------------------------------------------------------
module rename_regfile
    import rename_regfile_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rename_en,
    input  logic [REG_ID_BIT-1:0]    rename_rd,
    input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
    input  logic [REG_ID_BIT-1:0]    rs1,
    input  logic [REG_ID_BIT-1:0]    rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
    output logic [DATA_WIDTH-1:0]    rs1_value,
    output logic [DATA_WIDTH-1:0]    rs2_value,
    input  logic                     write_en,
    input  logic [REG_ID_BIT-1:0]    reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] rob_id,
    input  logic [DATA_WIDTH-1:0]    value_in,
    input  logic                     clear_all
);

    logic [DATA_WIDTH-1:0]    r_value [REG_NUM];
    logic                     r_busy  [REG_NUM];
    logic [ROB_WIDTH_BIT-1:0] r_tag   [REG_NUM];

    logic w_commit;
    logic w_commitResolves;
    logic w_rename;

    // A commit always writes its value (except to x0). It only releases the
    // busy bit when it comes from the producer the register currently waits
    // on; otherwise a younger rename is still outstanding.
    assign w_commit         = write_en && isArchWrite(reg_id);
    assign w_commitResolves = w_commit && r_busy[reg_id] && (r_tag[reg_id] == rob_id);
    assign w_rename         = rename_en && isArchWrite(rename_rd) && !clear_all;

    // State update. Ordering of the non-blocking assignments matters: the
    // flush and the rename come after the commit's busy release so that,
    // on the same register in the same cycle, the rename (or the flush) has
    // the final say on busy and tag while the commit value still lands.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (w_commit) begin
                r_value[reg_id] <= value_in;
            end
            if (w_commitResolves) begin
                r_busy[reg_id] <= 1'b0;
            end
            if (clear_all) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end else if (w_rename) begin
                r_busy[rename_rd] <= 1'b1;
                r_tag[rename_rd]  <= rename_rob_id;
            end
        end
    end

    // Two identical operand lookups, one per source register.
    rename_regfile_read_port u_readPortRs1 (
        .i_rs      (rs1),
        .i_values  (r_value),
        .i_busy    (r_busy),
        .i_tags    (r_tag),
        .i_writeEn (write_en),
        .i_regId   (reg_id),
        .i_robId   (rob_id),
        .i_valueIn (value_in),
        .o_busy    (rs1_busy),
        .o_tag     (rs1_tag),
        .o_value   (rs1_value)
    );

    rename_regfile_read_port u_readPortRs2 (
        .i_rs      (rs2),
        .i_values  (r_value),
        .i_busy    (r_busy),
        .i_tags    (r_tag),
        .i_writeEn (write_en),
        .i_regId   (reg_id),
        .i_robId   (rob_id),
        .i_valueIn (value_in),
        .o_busy    (rs2_busy),
        .o_tag     (rs2_tag),
        .o_value   (rs2_value)
    );

endmodule
